// File: rtl/histogram_verici.sv
// Frame histogram: clears 256 bins, counts one frame of 8-bit pixels, then streams the bins in index order.
// Optional HISTOGRAM_KUMULATIF_EN: streamed value is the running cumulative sum (CDF) instead of the raw bin.
module histogram_verici #(
  parameter int unsigned PIKSEL_SAYISI = 76800,
  parameter int unsigned SAYAC_W       = 24
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic [7:0]  piksel_i,
  input  logic        piksel_gecerli_i,
  output logic        piksel_hazir_o,
  input  logic        veri_al_his_i,
  input  logic        his_ack_i,
  output logic [31:0] veri_histogram_o,
  output logic        his_gecerli_o,
  output logic        islem_bitti_o
);

  localparam int unsigned CNT_W = $clog2(PIKSEL_SAYISI + 1);
  localparam int unsigned IDX_W = 8;
  localparam int unsigned BIN_N = 256;
  localparam int unsigned VAL_W = 24;

  typedef enum logic [2:0] {TEMIZLE, SAY, BEKLE, OKU, GONDER, BITTI} durum_t;

  durum_t               durum_q, durum_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 hazir_q, hazir_d;
  logic [31:0]          veri_q, veri_d;
  logic                 gecerli_q, gecerli_d;
  logic                 bitti_q, bitti_d;
  logic                 s1_gec_q, s1_gec_d;
  logic [IDX_W-1:0]     s1_pix_q, s1_pix_d;
  logic                 s2_gec_q, s2_gec_d;
  logic [IDX_W-1:0]     s2_pix_q, s2_pix_d;
  logic [SAYAC_W-1:0]   s2_val_q, s2_val_d;

  logic [SAYAC_W-1:0]   bin_mem_q [BIN_N];

  logic                 kabul_c, ack_c, sayim_bitti_c;
  logic                 wr_en_c;
  logic [IDX_W-1:0]     wr_addr_c;
  logic [SAYAC_W-1:0]   wr_data_c, okunan_c;
  logic [VAL_W-1:0]     deger_c;

  assign kabul_c        = en_i && piksel_gecerli_i && hazir_q;
  assign ack_c          = en_i && his_ack_i && gecerli_q;
  assign sayim_bitti_c  = (cnt_q == CNT_W'(PIKSEL_SAYISI));
  assign piksel_hazir_o = hazir_q && en_i;

  // Stage-1 read forwards the not-yet-written stage-2 result for equal back-to-back pixels
  assign okunan_c = (s2_gec_q && (s2_pix_q == s1_pix_q)) ? s2_val_q : bin_mem_q[s1_pix_q];

`ifdef HISTOGRAM_KUMULATIF_EN
  logic [VAL_W-1:0] acc_q, acc_d;
  logic [VAL_W:0]   toplam_c;

  assign toplam_c = {1'b0, acc_q} + (VAL_W + 1)'(bin_mem_q[idx_q]);
  assign deger_c  = toplam_c[VAL_W] ? {VAL_W{1'b1}} : toplam_c[VAL_W-1:0];

  // Accumulator advances only on an accepted bin, so pauses leave it intact
  always_comb begin
    acc_d = acc_q;
    if (ack_c) acc_d = veri_q[VAL_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) acc_q <= '0;
    else         acc_q <= acc_d;
  end
`else
  assign deger_c = VAL_W'(bin_mem_q[idx_q]);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      durum_q   <= TEMIZLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      hazir_q   <= 1'b0;
      veri_q    <= '0;
      gecerli_q <= 1'b0;
      bitti_q   <= 1'b0;
      s1_gec_q  <= 1'b0;
      s1_pix_q  <= '0;
      s2_gec_q  <= 1'b0;
      s2_pix_q  <= '0;
      s2_val_q  <= '0;
    end else begin
      durum_q   <= durum_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      hazir_q   <= hazir_d;
      veri_q    <= veri_d;
      gecerli_q <= gecerli_d;
      bitti_q   <= bitti_d;
      s1_gec_q  <= s1_gec_d;
      s1_pix_q  <= s1_pix_d;
      s2_gec_q  <= s2_gec_d;
      s2_pix_q  <= s2_pix_d;
      s2_val_q  <= s2_val_d;
    end
  end

  // Bin storage has no reset; TEMIZLE clears it
  always_ff @(posedge clk_i) begin
    if (wr_en_c) bin_mem_q[wr_addr_c] <= wr_data_c;
  end

  always_comb begin
    durum_d = durum_q;
    if (en_i) begin
      unique case (durum_q)
        TEMIZLE: if (idx_q == IDX_W'(BIN_N - 1)) durum_d = SAY;
        SAY:     if (sayim_bitti_c && !s1_gec_q) durum_d = BEKLE;
        BEKLE:   if (veri_al_his_i) durum_d = OKU;
        OKU:     durum_d = veri_al_his_i ? GONDER : BEKLE;
        GONDER: begin
          if (ack_c) begin
            if (idx_q == IDX_W'(BIN_N - 1)) durum_d = BITTI;
            else                            durum_d = veri_al_his_i ? OKU : BEKLE;
          end else if (!veri_al_his_i) begin
            durum_d = BEKLE;
          end
        end
        BITTI:   durum_d = BITTI;
        default: durum_d = TEMIZLE;
      endcase
    end
  end

  always_comb begin
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    hazir_d   = hazir_q;
    veri_d    = veri_q;
    gecerli_d = gecerli_q;
    bitti_d   = bitti_q;
    s1_gec_d  = s1_gec_q;
    s1_pix_d  = s1_pix_q;
    s2_gec_d  = s2_gec_q;
    s2_pix_d  = s2_pix_q;
    s2_val_d  = s2_val_q;
    wr_en_c   = 1'b0;
    wr_addr_c = s2_pix_q;
    wr_data_c = s2_val_q;
    if (en_i) begin
      s1_gec_d = kabul_c;
      if (kabul_c) begin
        s1_pix_d = piksel_i;
        cnt_d    = cnt_q + CNT_W'(1);
      end
      s2_gec_d = s1_gec_q;
      s2_pix_d = s1_pix_q;
      s2_val_d = (&okunan_c) ? okunan_c : okunan_c + SAYAC_W'(1);
      wr_en_c  = s2_gec_q;
      hazir_d  = (durum_d == SAY) && (cnt_d != CNT_W'(PIKSEL_SAYISI));
      unique case (durum_q)
        TEMIZLE: begin
          wr_en_c   = 1'b1;
          wr_addr_c = idx_q;
          wr_data_c = '0;
          idx_d     = idx_q + IDX_W'(1);
        end
        OKU: begin
          if (veri_al_his_i) begin
            veri_d    = {idx_q, deger_c};
            gecerli_d = 1'b1;
          end
        end
        GONDER: begin
          if (ack_c) begin
            gecerli_d = 1'b0;
            idx_d     = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(BIN_N - 1)) bitti_d = 1'b1;
          end else if (!veri_al_his_i) begin
            gecerli_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign veri_histogram_o = veri_q;
  assign his_gecerli_o    = gecerli_q;
  assign islem_bitti_o    = bitti_q;

endmodule

// File: tb/tb_histogram_verici.sv
// Directed bench for histogram_verici with a short frame and 8-bit bins so saturation is reachable.
module tb_histogram_verici;

  localparam int unsigned N   = 300;
  localparam int unsigned W   = 8;
  localparam int          MAX = 255;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        en_i = 1'b1;
  logic [7:0]  piksel_i = '0;
  logic        piksel_gecerli_i = 1'b0;
  logic        piksel_hazir_o;
  logic        veri_al_his_i = 1'b0;
  logic        his_ack_i = 1'b0;
  logic [31:0] veri_histogram_o;
  logic        his_gecerli_o;
  logic        islem_bitti_o;

  int checks = 0;
  int failures = 0;
  int pix[$];
  int exp_bin[256];

  histogram_verici #(.PIKSEL_SAYISI(N), .SAYAC_W(W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
    .piksel_i(piksel_i), .piksel_gecerli_i(piksel_gecerli_i), .piksel_hazir_o(piksel_hazir_o),
    .veri_al_his_i(veri_al_his_i), .his_ack_i(his_ack_i),
    .veri_histogram_o(veri_histogram_o), .his_gecerli_o(his_gecerli_o), .islem_bitti_o(islem_bitti_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic compute_expected();
    int acc;
    for (int i = 0; i < 256; i++) exp_bin[i] = 0;
    foreach (pix[k]) if (exp_bin[pix[k]] < MAX) exp_bin[pix[k]]++;
`ifdef HISTOGRAM_KUMULATIF_EN
    acc = 0;
    for (int i = 0; i < 256; i++) begin
      acc = acc + exp_bin[i];
      if (acc > 24'hFFFFFF) acc = 24'hFFFFFF;
      exp_bin[i] = acc;
    end
`else
    acc = 0;
`endif
  endtask

  task automatic build_ramp();
    pix.delete();
    for (int i = 0; i < N; i++) pix.push_back(i % 256);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0; en_i = 1'b1; piksel_gecerli_i = 1'b0;
    veri_al_his_i = 1'b0; his_ack_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!piksel_hazir_o && w < 400) begin @(negedge clk_i); w++; end
    checks++;
    if (!piksel_hazir_o) begin failures++; $display("FAIL ready_timeout hazir=%0b after %0d cycles", piksel_hazir_o, w); end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (piksel_hazir_o !== 1'b0 || veri_histogram_o !== 32'h0 || his_gecerli_o !== 1'b0 || islem_bitti_o !== 1'b0) begin
      failures++;
      $display("FAIL %s got hazir=%b veri=%h gecerli=%b bitti=%b required all 0", tag,
               piksel_hazir_o, veri_histogram_o, his_gecerli_o, islem_bitti_o);
    end
  endtask

  // Feeds pix[], optionally with valid gaps and an en_i=0 window; then checks drain latency
  task automatic feed(input int gap_every, input int en_start, input int en_len);
    int k = 0;
    int c = 0;
    int lat;
    while (k < pix.size() && c < 5000) begin
      @(negedge clk_i);
      en_i = !(en_len > 0 && c >= en_start && c < en_start + en_len);
      if (gap_every > 0 && (c % gap_every) == gap_every - 1) piksel_gecerli_i = 1'b0;
      else begin piksel_gecerli_i = 1'b1; piksel_i = 8'(pix[k]); end
      #1;
      if (!en_i) begin
        checks++;
        if (piksel_hazir_o !== 1'b0) begin failures++; $display("FAIL hazir_when_disabled got=%b required=0", piksel_hazir_o); end
      end
      if (piksel_gecerli_i && piksel_hazir_o) k++;
      c++;
    end
    en_i = 1'b1;
    checks++;
    if (k < pix.size()) begin failures++; $display("FAIL feed_timeout accepted=%0d required=%0d", k, pix.size()); end
    @(negedge clk_i);
    piksel_gecerli_i = 1'b0;
    lat = 1;
    checks++;
    if (piksel_hazir_o !== 1'b0) begin failures++; $display("FAIL hazir_after_frame got=%b required=0", piksel_hazir_o); end
    while (!his_gecerli_o && lat < 20) begin @(negedge clk_i); lat++; end
    checks++;
    if (lat !== 5) begin failures++; $display("FAIL first_bin_latency got=%0d required=5", lat); end
  endtask

  // Collects n_bins bins, acking each; optional request-drop pause after acking pause_at
  task automatic collect(input int n_bins, input int pause_at);
    logic [31:0] exp_w;
    for (int i = 0; i < n_bins; i++) begin
      int w = 0;
      while (!his_gecerli_o && w < 20) begin @(negedge clk_i); w++; end
      checks++;
      if (!his_gecerli_o) begin failures++; $display("FAIL bin_timeout idx=%0d gecerli=%b required=1", i, his_gecerli_o); return; end
      exp_w = {8'(i), 24'(exp_bin[i])};
      checks++;
      if (veri_histogram_o !== exp_w) begin
        failures++; $display("FAIL bin_data idx=%0d got=%h required=%h", i, veri_histogram_o, exp_w);
      end
      if (i == 255) begin
        checks++;
        if (islem_bitti_o !== 1'b0) begin failures++; $display("FAIL bitti_early got=%b required=0", islem_bitti_o); end
      end
      his_ack_i = 1'b1;
      @(negedge clk_i);
      his_ack_i = 1'b0;
      if (i == pause_at) begin
        veri_al_his_i = 1'b0;
        for (int j = 0; j < 20; j++) begin
          his_ack_i = (j == 10);
          @(negedge clk_i);
          checks++;
          if (his_gecerli_o !== 1'b0) begin failures++; $display("FAIL pause_gecerli step=%0d got=%b required=0", j, his_gecerli_o); end
        end
        his_ack_i = 1'b0;
        veri_al_his_i = 1'b1;
      end
    end
    if (n_bins == 256) begin
      @(negedge clk_i);
      checks++;
      if (islem_bitti_o !== 1'b1 || his_gecerli_o !== 1'b0) begin
        failures++; $display("FAIL done_state bitti=%b gecerli=%b required bitti=1 gecerli=0", islem_bitti_o, his_gecerli_o);
      end
      his_ack_i = 1'b1;
      repeat (3) @(negedge clk_i);
      his_ack_i = 1'b0;
      repeat (3) @(negedge clk_i);
      checks++;
      if (islem_bitti_o !== 1'b1 || his_gecerli_o !== 1'b0) begin
        failures++; $display("FAIL idle_after_done bitti=%b gecerli=%b required bitti=1 gecerli=0", islem_bitti_o, his_gecerli_o);
      end
    end
  endtask

  task automatic test_reset();
    int w = 0;
    #2 rst_ni = 1'b0;
    #1 check_reset_outputs("reset_values");
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    while (!piksel_hazir_o && w < 400) begin @(negedge clk_i); w++; end
    checks++;
    if (w !== 256) begin failures++; $display("FAIL clear_duration got=%0d required=256", w); end
  endtask

  task automatic test_all_zero();
    pix.delete();
    for (int i = 0; i < N; i++) pix.push_back(0);
    compute_expected();
    veri_al_his_i = 1'b1;
    feed(0, 0, 0);
    collect(256, -1);
  endtask

  task automatic test_ramp_pause();
    do_reset(); wait_ready();
    build_ramp(); compute_expected();
    veri_al_his_i = 1'b1;
    feed(7, 0, 0);
    collect(256, 9);
  endtask

  task automatic test_forwarding();
    int head[13] = '{5, 5, 5, 7, 7, 5, 9, 9, 3, 4, 3, 4, 3};
    do_reset(); wait_ready();
    pix.delete();
    foreach (head[i]) pix.push_back(head[i]);
    while (pix.size() < N) pix.push_back(200);
    compute_expected();
    veri_al_his_i = 1'b1;
    feed(0, 0, 0);
    collect(256, -1);
  endtask

  task automatic test_enable();
    do_reset(); wait_ready();
    build_ramp(); compute_expected();
    veri_al_his_i = 1'b1;
    feed(0, 100, 50);
    collect(256, -1);
  endtask

  task automatic test_reset_mid_send();
    do_reset(); wait_ready();
    build_ramp(); compute_expected();
    veri_al_his_i = 1'b1;
    feed(7, 0, 0);
    collect(50, -1);
    #2 rst_ni = 1'b0;
    #1 check_reset_outputs("reset_mid_send");
    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset_held");
    rst_ni = 1'b1;
    wait_ready();
    feed(7, 0, 0);
    collect(256, -1);
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_ramp_pause();
    test_forwarding();
    test_enable();
    test_reset_mid_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
